// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read, dual-write integer register file with a
// per-register busy scoreboard for WAW/RAW hazard tracking. Register 0 is
// hard-wired to zero.
//
// Optional build macro REGFILE_BYPASS_EN: same-cycle writeback data is
// forwarded to every read port. A matching read then reports not-busy, and a
// same-cycle writeback to issue_rd lets that issue be accepted on the edge.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2
) (
    input  logic                         SYS_clk,
    input  logic                         SYS_reset,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*XLEN-1:0]     rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_rd,
    output logic                         issue_ready,
    input  logic                         wb0_en,
    input  logic [ADDR_W-1:0]            wb0_addr,
    input  logic [XLEN-1:0]              wb0_data,
    input  logic                         wb1_en,
    input  logic [ADDR_W-1:0]            wb1_addr,
    input  logic [XLEN-1:0]              wb1_data,
    output logic [ADDR_W:0]              busy_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    logic wb0_hit;
    logic wb1_hit;
    logic issue_accept;
    logic issue_wb_clear;

    // Writes to x0 are discarded everywhere, so qualify them once here.
    assign wb0_hit = wb0_en && (wb0_addr != '0);
    assign wb1_hit = wb1_en && (wb1_addr != '0);

    // A writeback landing on issue_rd this cycle; only forwarding builds use it.
    assign issue_wb_clear = (wb0_hit && (wb0_addr == issue_rd)) ||
                            (wb1_hit && (wb1_addr == issue_rd));

    // Issue is ready when the destination is free (x0 is always free).
    always_comb begin
        issue_ready = (issue_rd == '0) || !busy[issue_rd];
`ifdef REGFILE_BYPASS_EN
        if (issue_wb_clear) begin
            issue_ready = 1'b1;
        end
`endif
    end

    assign issue_accept = issue_valid && issue_ready;

    // Next scoreboard: writebacks clear first, then an accepted issue sets,
    // so a reservation wins over a same-edge clear of the same register.
    always_comb begin
        busy_next = busy;
        if (wb0_hit) begin
            busy_next[wb0_addr] = 1'b0;
        end
        if (wb1_hit) begin
            busy_next[wb1_addr] = 1'b0;
        end
        if (issue_accept && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    // Scoreboard register; reset drops every outstanding reservation.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Register array; port 1 is applied after port 0 so it wins a same-address conflict.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb0_hit) begin
                regs[wb0_addr] <= wb0_data;
            end
            if (wb1_hit) begin
                regs[wb1_addr] <= wb1_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;
        logic [XLEN-1:0]   data_k;
        logic              busy_k;

        assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

        // Combinational read of one port: x0 reads zero/not-busy, optional forwarding.
        always_comb begin
            data_k = regs[addr_k];
            busy_k = busy[addr_k];
            if (addr_k == '0) begin
                data_k = '0;
                busy_k = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            if (wb1_hit && (wb1_addr == addr_k)) begin
                data_k = wb1_data;
                busy_k = 1'b0;
            end else if (wb0_hit && (wb0_addr == addr_k)) begin
                data_k = wb0_data;
                busy_k = 1'b0;
            end
`endif
        end

        assign rd_data[k*XLEN +: XLEN] = data_k;
        assign rd_busy[k]              = busy_k;
    end

    // Population count of the scoreboard.
    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_count = busy_count + {{ADDR_W{1'b0}}, busy[i]};
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// randomized traffic, all compared against a behavioural array model.
module tb_regfile_scoreboard;

    localparam int XLEN     = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_READ = 2;
    localparam int NR       = 32;

    logic                       SYS_clk = 1'b0;
    logic                       SYS_reset;
    logic [NUM_READ*ADDR_W-1:0] rd_addr;
    logic [NUM_READ*XLEN-1:0]   rd_data;
    logic [NUM_READ-1:0]        rd_busy;
    logic                       issue_valid;
    logic [ADDR_W-1:0]          issue_rd;
    logic                       issue_ready;
    logic                       wb0_en;
    logic [ADDR_W-1:0]          wb0_addr;
    logic [XLEN-1:0]            wb0_data;
    logic                       wb1_en;
    logic [ADDR_W-1:0]          wb1_addr;
    logic [XLEN-1:0]            wb1_data;
    logic [ADDR_W:0]            busy_count;

    always #5 SYS_clk = ~SYS_clk;

    regfile_scoreboard #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ)) dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset   (SYS_reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb0_en      (wb0_en),
        .wb0_addr    (wb0_addr),
        .wb0_data    (wb0_data),
        .wb1_en      (wb1_en),
        .wb1_addr    (wb1_addr),
        .wb1_data    (wb1_data),
        .busy_count  (busy_count)
    );

    // Reference model: architectural register values and reservation flags.
    logic [XLEN-1:0] m_regs [NR];
    bit              m_busy [NR];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit wb0_to(input logic [ADDR_W-1:0] a);
        return wb0_en && (wb0_addr != 0) && (wb0_addr == a);
    endfunction

    function automatic bit wb1_to(input logic [ADDR_W-1:0] a);
        return wb1_en && (wb1_addr != 0) && (wb1_addr == a);
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wb1_to(a)) return wb1_data;
        if (wb0_to(a)) return wb0_data;
`endif
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wb0_to(a) || wb1_to(a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic bit exp_ready();
        if (issue_rd == 0) return 1'b1;
`ifdef REGFILE_BYPASS_EN
        if (wb0_to(issue_rd) || wb1_to(issue_rd)) return 1'b1;
`endif
        return !m_busy[issue_rd];
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < NUM_READ; k++) begin
            logic [ADDR_W-1:0] a;
            a = rd_addr[k*ADDR_W +: ADDR_W];
            chk($sformatf("rd_data[%0d] x%0d", k, a), 64'(rd_data[k*XLEN +: XLEN]), 64'(exp_data(a)));
            chk($sformatf("rd_busy[%0d] x%0d", k, a), 64'(rd_busy[k]), 64'(exp_busy(a)));
        end
        chk("issue_ready", 64'(issue_ready), 64'(exp_ready()));
        chk("busy_count", 64'(busy_count), 64'(exp_count()));
    endtask

    // Apply inputs for one cycle and let combinational outputs settle.
    task automatic drive(input bit rst, input bit iv, input int ird,
                         input bit w0e, input int w0a, input logic [XLEN-1:0] w0d,
                         input bit w1e, input int w1a, input logic [XLEN-1:0] w1d,
                         input int ra0, input int ra1);
        SYS_reset   = rst;
        issue_valid = iv;
        issue_rd    = ADDR_W'(ird);
        wb0_en      = w0e;
        wb0_addr    = ADDR_W'(w0a);
        wb0_data    = w0d;
        wb1_en      = w1e;
        wb1_addr    = ADDR_W'(w1a);
        wb1_data    = w1d;
        rd_addr     = {ADDR_W'(ra1), ADDR_W'(ra0)};
        #1;
    endtask

    task automatic idle(input int ra0, input int ra1, input int ird);
        drive(0, 0, ird, 0, 0, '0, 0, 0, '0, ra0, ra1);
    endtask

    // Check the settled outputs, clock one edge and advance the model.
    task automatic step();
        bit acc;
        check_outputs();
        acc = issue_valid && exp_ready();
        @(posedge SYS_clk);
        if (SYS_reset) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wb0_en && wb0_addr != 0) begin
                m_regs[wb0_addr] = wb0_data;
                m_busy[wb0_addr] = 1'b0;
            end
            if (wb1_en && wb1_addr != 0) begin
                m_regs[wb1_addr] = wb1_data;
                m_busy[wb1_addr] = 1'b0;
            end
            if (acc && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
        #1;
    endtask

    function automatic int pick_addr();
        if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, NR - 1));
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 'x;
            m_busy[i] = 1'b0;
        end
        @(posedge SYS_clk);
        #1;
        drive(1, 0, 0, 0, 0, '0, 0, 0, '0, 0, 0);
        @(posedge SYS_clk);
        #1;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        step();

        // Reset state
        idle(5, 31, 7);
        chk("reset rd_data0", 64'(rd_data[31:0]), 64'h0);
        chk("reset rd_busy", 64'(rd_busy), 64'h0);
        chk("reset busy_count", 64'(busy_count), 64'h0);
        chk("reset issue_ready", 64'(issue_ready), 64'h1);
        step();

        // Write then read back x5
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, '0, 5, 0);
`ifdef REGFILE_BYPASS_EN
        chk("t1 same-cycle x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
`else
        chk("t1 pre-edge x5", 64'(rd_data[31:0]), 64'h0);
`endif
        step();
        idle(5, 0, 0);
        chk("t1 post-edge x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        step();

        // x0 protection
        drive(1'b0, 1'b1, 0, 1'b1, 0, 32'h12345678, 1'b0, 0, '0, 0, 0);
        chk("t2 ready x0", 64'(issue_ready), 64'h1);
        step();
        idle(0, 0, 0);
        chk("t2 x0 data", 64'(rd_data[31:0]), 64'h0);
        chk("t2 x0 busy", 64'(rd_busy[0]), 64'h0);
        chk("t2 count", 64'(busy_count), 64'h0);
        chk("t2 ready", 64'(issue_ready), 64'h1);
        step();

        // Scoreboard reserve / release on x7
        drive(0, 1, 7, 0, 0, '0, 0, 0, '0, 7, 0);
        step();
        idle(7, 0, 7);
        chk("t3 busy x7", 64'(rd_busy[0]), 64'h1);
        chk("t3 count", 64'(busy_count), 64'h1);
        chk("t3 ready x7", 64'(issue_ready), 64'h0);
        step();
        drive(0, 0, 7, 0, 0, '0, 1, 7, 32'h55, 7, 0);
        step();
        idle(7, 0, 7);
        chk("t3 cleared busy", 64'(rd_busy[0]), 64'h0);
        chk("t3 data x7", 64'(rd_data[31:0]), 64'h55);
        chk("t3 count after", 64'(busy_count), 64'h0);
        step();

        // Same-address write conflict
        drive(0, 0, 0, 1, 9, 32'h1111, 1, 9, 32'h2222, 0, 0);
        step();
        idle(9, 0, 0);
        chk("t4 x9 wb1 wins", 64'(rd_data[31:0]), 64'h2222);
        step();

        // Mid-operation reset
        drive(0, 1, 3, 0, 0, '0, 0, 0, '0, 0, 0); step();
        drive(0, 1, 4, 0, 0, '0, 0, 0, '0, 0, 0); step();
        drive(0, 1, 10, 0, 0, '0, 0, 0, '0, 0, 0); step();
        idle(3, 4, 0);
        chk("t5 count 3", 64'(busy_count), 64'h3);
        step();
        drive(1, 0, 0, 1, 3, 32'h99, 0, 0, '0, 3, 4);
        step();
        idle(3, 5, 10);
        chk("t5 count 0", 64'(busy_count), 64'h0);
        chk("t5 x3 data", 64'(rd_data[31:0]), 64'h0);
        chk("t5 x5 data", 64'(rd_data[63:32]), 64'h0);
        chk("t5 ready x10", 64'(issue_ready), 64'h1);
        step();

        // Writeback and issue to the same busy register
        drive(0, 1, 12, 0, 0, '0, 0, 0, '0, 0, 0); step();
        drive(0, 1, 12, 1, 12, 32'hCAFE, 0, 0, '0, 0, 12);
`ifdef REGFILE_BYPASS_EN
        chk("t6 fwd data", 64'(rd_data[63:32]), 64'hCAFE);
        chk("t6 fwd busy", 64'(rd_busy[1]), 64'h0);
        chk("t6 ready", 64'(issue_ready), 64'h1);
        step();
        idle(0, 12, 0);
        chk("t6 x12 stays busy", 64'(rd_busy[1]), 64'h1);
        chk("t6 x12 data", 64'(rd_data[63:32]), 64'hCAFE);
        step();
`else
        chk("t6 no-fwd data", 64'(rd_data[63:32]), 64'h0);
        chk("t6 stalled", 64'(issue_ready), 64'h0);
        step();
        drive(0, 1, 12, 0, 0, '0, 0, 0, '0, 0, 12);
        chk("t6 ready next", 64'(issue_ready), 64'h1);
        chk("t6 data next", 64'(rd_data[63:32]), 64'hCAFE);
        step();
        idle(0, 12, 0);
        chk("t6 x12 busy again", 64'(rd_busy[1]), 64'h1);
        step();
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, pick_addr(),
                  $urandom_range(0, 2) != 0, pick_addr(), $urandom(),
                  $urandom_range(0, 2) != 0, pick_addr(), $urandom(),
                  pick_addr(), pick_addr());
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
